bcd_serial_adder: RTL and testbench

//   Multi-digit packed-BCD adder, digit-serial: one BCD digit per clock, LSD first, with ripple carry.

---
 rtl/bcd_serial_adder_pkg.sv | 20 ++
 rtl/bcd_serial_adder_if.sv | 27 ++
 rtl/bcd_serial_adder_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 129 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for bcd_serial_adder; slave is the adder side.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// Single BCD digit adder with decimal (+6) correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       ci,
  output bcd_digit_t s_d,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a_d} + {1'b0, b_d} + {4'd0, ci};
    if (t > {1'b0, BCD_MAX}) begin
      s_d = t[3:0] + BCD_CORR;
      co  = 1'b1;
    end else begin
      s_d = t[3:0];
      co  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock, valid/ready on both sides.
// Optional operand digit checking is enabled by defining BCD_CHECK_EN.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operation
//   RUN   | adding digit idx, carry rippling between cycles
//   DONE  | out_valid=1, result held until out_ready
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic                    carry;
  bcd_digit_t [DIGITS-1:0] a_q;
  bcd_digit_t [DIGITS-1:0] b_q;
  bcd_digit_t [DIGITS-1:0] sum_q;
  logic                    cout_q;
  logic                    err_hold;

  bcd_digit_t dig_s;
  logic       dig_co;
  logic       accept;
  logic       handoff;

  assign accept  = bus.in_valid && (state == S_IDLE);
  assign handoff = bus.out_ready && (state == S_DONE);

  // One shared digit adder; the operand digit is selected by idx.
  bcd_digit_add u_digit (
    .a_d (a_q[idx]),
    .b_d (b_q[idx]),
    .ci  (carry),
    .s_d (dig_s),
    .co  (dig_co)
  );

`ifdef BCD_CHECK_EN
  logic bad_in;
  logic err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(bus.a[4*i +: 4]) || !is_bcd(bus.b[4*i +: 4])) begin
        bad_in = 1'b1;
      end
    end
  end

  // Error is latched at acceptance and released only when the result is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= bad_in;
    end else if (handoff) begin
      err_q <= 1'b0;
    end
  end

  assign err_hold = err_q;
`else
  assign err_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A flagged operation still walks every digit but reports a zero result.
          sum_q[idx] <= err_hold ? '0 : dig_s;
          carry      <= dig_co;
          if (idx == IDX_LAST) begin
            cout_q <= dig_co & ~err_hold;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (handoff) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_hold;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4) with hand-computed BCD results.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives one operation, measures clocks from accept to out_valid, then hands the result off.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] s, output logic co, output logic e, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20 && bus.out_valid !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    s = bus.sum; co = bus.cout; e = bus.err;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co, e; int lat;
    do_op(16'h1234, 16'h5678, 1'b0, s, co, e, lat);
    checks++; if (s !== 16'h6912) begin errors++; $display("FAIL basic_sum got=%h exp=6912", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", co); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_handoff_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_ripple_and_max();
    logic [15:0] s; logic co, e; int lat;
    do_op(16'h9999, 16'h0000, 1'b1, s, co, e, lat);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL ripple_sum got=%h exp=0000", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", co); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    do_op(16'h9999, 16'h9999, 1'b1, s, co, e, lat);
    checks++; if (s !== 16'h9999) begin errors++; $display("FAIL max_sum got=%h exp=9999", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL max_cout got=%b exp=1", co); end
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'h0000, 16'h5000, 16'h0001, 16'h4567, 16'h0890};
    logic [15:0] vb [5] = '{16'h0000, 16'h5000, 16'h0009, 16'h5433, 16'h0110};
    logic        vc [5] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
    logic [15:0] vs [5] = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h1001};
    logic        vo [5] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    logic [15:0] s; logic co, e; int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], s, co, e, lat);
      checks++; if (s !== vs[i]) begin errors++; $display("FAIL vec%0d_sum got=%h exp=%h", i, s, vs[i]); end
      checks++; if (co !== vo[i]) begin errors++; $display("FAIL vec%0d_cout got=%b exp=%b", i, co, vo[i]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] s; logic co, e; int lat;
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20 && bus.out_valid !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.a = 16'h9999; bus.b = 16'h8888;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.sum !== 16'h5432) begin errors++; $display("FAIL hold%0d_sum got=%h exp=5432", i, bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL hold%0d_cout got=%b exp=0", i, bus.cout); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", bus.in_ready); end
    do_op(16'h0002, 16'h0003, 1'b0, s, co, e, lat);
    checks++; if (s !== 16'h0005) begin errors++; $display("FAIL hold_next_sum got=%h exp=0005", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL hold_next_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, e; int lat; logic seen;
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse got=%b exp=0", seen); end
    do_op(16'h0005, 16'h0005, 1'b0, s, co, e, lat);
    checks++; if (s !== 16'h0010) begin errors++; $display("FAIL midrst_next_sum got=%h exp=0010", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL midrst_next_cout got=%b exp=0", co); end
  endtask

  task automatic test_err();
    logic [15:0] s; logic co, e; int lat;
    do_op(16'h12A4, 16'h0000, 1'b0, s, co, e, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL err_latency got=%0d exp=4", lat); end
`ifdef BCD_CHECK_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", e); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL err_sum got=%h exp=0000", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL err_cout got=%b exp=0", co); end
`else
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_flag_off got=%b exp=0", e); end
`endif
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", bus.err); end
  endtask

  task automatic test_back_to_back();
    int acc [2]; logic [15:0] res [4]; int n_acc; int n_res;
    n_acc = 0; n_res = 0;
    acc[0] = 0; acc[1] = 0;
    bus.a = 16'h0123; bus.b = 16'h0456; bus.cin = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (n_acc >= 2) bus.in_valid = 1'b0;
      else if (n_acc == 1) begin bus.a = 16'h0800; bus.b = 16'h0300; end
      if (bus.out_valid === 1'b1) begin
        if (n_res < 4) res[n_res] = bus.sum;
        n_res++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        if (n_acc < 2) acc[n_acc] = i;
        n_acc++;
      end
    end
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checks++; if (n_acc !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
    checks++; if (acc[1] - acc[0] !== 6) begin errors++; $display("FAIL b2b_spacing got=%0d exp=6", acc[1] - acc[0]); end
    checks++; if (n_res !== 2) begin errors++; $display("FAIL b2b_results got=%0d exp=2", n_res); end
    checks++; if (res[0] !== 16'h0579) begin errors++; $display("FAIL b2b_sum0 got=%h exp=0579", res[0]); end
    checks++; if (res[1] !== 16'h1100) begin errors++; $display("FAIL b2b_sum1 got=%h exp=1100", res[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple_and_max();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_err();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
